// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the bus-mapped down-counting timer:
//   - timer_state_t : FSM state encoding (IDLE/LOAD/CNT/INT)
//   - timer_addr_t  : word addresses on the bridge bus (Addr = bus bits [3:2])
//   - timer_mode_t  : CTRL.Mode codes (only RELOAD auto-restarts)
//   - CTRL_* bit positions
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_t;

  typedef enum logic [1:0] {
    ADDR_CTRL   = 2'd0,
    ADDR_PRESET = 2'd1,
    ADDR_COUNT  = 2'd2,
    ADDR_RSVD   = 2'd3
  } timer_addr_t;

  // Mode 0 is the one-shot level interrupt; 2 and 3 behave like mode 0.
  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_ALT2    = 2'd2,
    MODE_ALT3    = 2'd3
  } timer_mode_t;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // True when terminal count should reload and pulse instead of stopping.
  function automatic logic is_reload(input timer_mode_t mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//   Count-tick generator: o_tick is high for one cycle every PRESCALE cycles
//   while i_en is high. i_clear restarts the divider at 0.
//   Ports:
//     i_clk    : clock, rising edge
//     i_rst_n  : asynchronous active-low reset
//     i_clear  : synchronous restart of the divider
//     i_en     : divider advances only while high
//     o_tick   : one-cycle tick (combinational from the divider register)
//   Parameter PRESCALE (>=1): cycles per tick.
// -----------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
    end
  end

  // Tick on the last divider phase, so the first tick after a clear lands
  // PRESCALE enabled cycles later.
  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/timer_device.sv
// -----------------------------------------------------------------------------
// timer_device
//   Programmable 32-bit down-counting timer on the bridge bus. Its interrupt
//   feeds one bit of CP0 HWInt[5:0].
//   Register map (word address = Addr):
//     0 CTRL   R/W  bit0 Enable, bits[2:1] Mode, bit3 IM; bits[31:4] read 0
//     1 PRESET R/W  32-bit reload value
//     2 COUNT  RO   current count (writes ignored)
//     3 -      reads 0, writes ignored
//   Ports:
//     Clock       : single clock, rising edge
//     Reset       : asynchronous, active-low
//     Addr[1:0]   : word select
//     WE          : write enable for the selected register
//     WD[31:0]    : write data
//     RD[31:0]    : combinational read data for Addr
//     IRQ         : irq_flag & IM, both operands are flops
//     o_dbg_state : current FSM state (timer_pkg::timer_state_t encoding)
//   Configuration macro: TIMER_PRESCALE_EN. When defined, the count ticks once
//   every PRESCALE cycles in CNT via timer_prescaler; otherwise every cycle.
//
//   Bus handshake: a write is a single-cycle strobe -- the selected register
//   captures WD on the rising edge where WE=1; there is no ready/stall, and a
//   read is a purely combinational decode of Addr with no side effects.
// -----------------------------------------------------------------------------
module timer_device
  import timer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ,
  output logic [1:0]  o_dbg_state
);

  // Register file
  logic         r_ctrl_en;
  timer_mode_t  r_ctrl_mode;
  logic         r_ctrl_im;
  logic [31:0]  r_preset;

  // FSM state and datapath
  timer_state_t r_state;
  logic [31:0]  r_count;
  logic         r_irq_flag;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_irq_clr;
  logic w_tick;

  assign w_wr_ctrl   = WE && (Addr == ADDR_CTRL);
  assign w_wr_preset = WE && (Addr == ADDR_PRESET);

  // A held (mode 0) flag is acknowledged by any CTRL/PRESET write; a reload
  // pulse drops by itself one cycle after it was raised.
  assign w_irq_clr = w_wr_ctrl || w_wr_preset ||
                     (r_irq_flag && is_reload(r_ctrl_mode));

`ifdef TIMER_PRESCALE_EN
  logic w_pre_clear;
  logic w_pre_en;

  assign w_pre_clear = (r_state == ST_LOAD);
  assign w_pre_en    = (r_state == ST_CNT);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_clear (w_pre_clear),
    .i_en    (w_pre_en),
    .o_tick  (w_tick)
  );
`else
  // Without the prescaler every CNT cycle is a tick; PRESCALE has no effect.
  assign w_tick = (PRESCALE > 0) || 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Bus-visible registers. A CTRL write in the same cycle the FSM would clear
  // Enable takes priority, so software never loses its own write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ctrl_en   <= 1'b0;
      r_ctrl_mode <= MODE_ONESHOT;
      r_ctrl_im   <= 1'b0;
      r_preset    <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl_en   <= WD[CTRL_EN_BIT];
        r_ctrl_mode <= timer_mode_t'(WD[CTRL_MODE_MSB:CTRL_MODE_LSB]);
        r_ctrl_im   <= WD[CTRL_IM_BIT];
      end else if ((r_state == ST_INT) && !is_reload(r_ctrl_mode)) begin
        r_ctrl_en <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= WD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. COUNT only changes in LOAD (reload) and CNT (decrement), so a
  // PRESET write mid-count takes effect at the next LOAD.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_irq_clr) begin
        r_irq_flag <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_ctrl_en) begin
            r_state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end

        ST_CNT: begin
          if (!r_ctrl_en) begin
            r_state <= ST_IDLE;
          end else if (r_count == 32'd0) begin
            // PRESET=0 lands here straight from LOAD; no underflow.
            r_state <= ST_INT;
          end else if (w_tick) begin
            r_count <= r_count - 32'd1;
            if (r_count == 32'd1) begin
              r_state <= ST_INT;
            end
          end
        end

        ST_INT: begin
          // Setting the flag here overrides a same-cycle clear request.
          r_irq_flag <= 1'b1;
          r_state    <= is_reload(r_ctrl_mode) ? ST_LOAD : ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    RD = '0;
    case (Addr)
      ADDR_CTRL:   RD = {28'd0, r_ctrl_im, r_ctrl_mode, r_ctrl_en};
      ADDR_PRESET: RD = r_preset;
      ADDR_COUNT:  RD = r_count;
      ADDR_RSVD:   RD = '0;
      default:     RD = '0;
    endcase
  end

  assign IRQ         = r_irq_flag & r_ctrl_im;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_device.sv
// -----------------------------------------------------------------------------
// tb_timer_device
//   Directed + randomized bench for timer_device. Expected COUNT/IRQ/CTRL per
//   clock edge come from closed-form timing rules (load two edges after the
//   Enable write, one decrement per tick, reload period, interrupt latency),
//   queued in exp_q and checked as the run steps through the edges.
// -----------------------------------------------------------------------------
module tb_timer_device;

`ifdef TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic        Clock;
  logic        Reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  timer_device #(
    .PRESCALE (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Addr        (Addr),
    .WE          (WE),
    .WD          (WD),
    .RD          (RD),
    .IRQ         (IRQ),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    WE    = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  // ---------------------------------------------------------------- drivers
  // Called at a falling edge; the next rising edge is the write edge, and the
  // task returns at the falling edge after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    WD   = d;
    WE   = 1'b1;
    @(negedge Clock);
    WE   = 1'b0;
    WD   = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = RD;
  endtask

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference timing after reset, PRESET=n, then CTRL={im,mode,Enable=1}
  // written on edge 0. Edge 2 is the LOAD edge; count ticks every P edges.
  function automatic void model(input int n, input int mode, input bit im, input int k,
                                output logic [31:0] cnt, output logic irq,
                                output logic [31:0] ctrl);
    int m, p, period, lat;
    bit en, flag;
    en   = 1'b1;
    flag = 1'b0;
    cnt  = 32'd0;
    if (k >= 2) begin
      m = k - 2;
      if (mode == 1) begin
        period = (n == 0) ? 3 : n * P + 2;
        p      = m % period;
        cnt    = (p <= n * P) ? 32'(n - p / P) : 32'd0;
        flag   = (p == period - 1);
      end else begin
        lat  = (n == 0) ? 2 : n * P + 1;
        cnt  = (m >= n * P) ? 32'd0 : 32'(n - m / P);
        flag = (m >= lat);
        en   = (m < lat);
      end
    end
    irq  = flag & im;
    ctrl = {28'd0, im, 2'(mode), en};
  endfunction

  task automatic run_trial(input int n, input int mode, input bit im, input int edges);
    logic [31:0] c, ct, r;
    logic q;
    do_reset();
    bus_write(A_PRESET, 32'(n));
    for (int k = 0; k < edges; k++) begin
      model(n, mode, im, k, c, q, ct);
      exp_q.push_back(c);
      exp_q.push_back({31'd0, q});
      exp_q.push_back(ct);
    end
    bus_write(A_CTRL, {28'd0, im, 2'(mode), 1'b1});
    for (int k = 0; k < edges; k++) begin
      if (k > 0) @(negedge Clock);
      bus_read(A_COUNT, r);
      check($sformatf("n%0d_m%0d_im%0d_k%0d_count", n, mode, im, k), r, exp_q.pop_front());
      check($sformatf("n%0d_m%0d_im%0d_k%0d_irq", n, mode, im, k), {31'd0, IRQ}, exp_q.pop_front());
      bus_read(A_CTRL, r);
      check($sformatf("n%0d_m%0d_im%0d_k%0d_ctrl", n, mode, im, k), r, exp_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] r, maxc, first_c, c;
    logic        found, changed, q;
    int          n, mode;
    bit          im;

    Reset = 1'b0;
    WE    = 1'b0;
    Addr  = 2'd0;
    WD    = 32'd0;

    // Reset values
    @(negedge Clock);
    bus_read(A_CTRL, r);   check("rst_ctrl", r, 32'd0);
    bus_read(A_PRESET, r); check("rst_preset", r, 32'd0);
    bus_read(A_COUNT, r);  check("rst_count", r, 32'd0);
    bus_read(A_RSVD, r);   check("rst_rsvd", r, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    Reset = 1'b1;

    // Mode 0, PRESET=3, IM=1: count 3,2,1,0 then held IRQ, Enable cleared
    run_trial(3, 0, 1'b1, 3 * P + 8);
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    check("rsvd_write_keeps_irq", {31'd0, IRQ}, 32'd1);
    bus_read(A_RSVD, r); check("rsvd_reads_zero", r, 32'd0);
    bus_write(A_COUNT, 32'd5);
    check("count_write_keeps_irq", {31'd0, IRQ}, 32'd1);
    bus_read(A_COUNT, r); check("count_write_keeps_count", r, 32'd0);
    bus_write(A_PRESET, 32'd3);
    check("preset_write_clears_irq", {31'd0, IRQ}, 32'd0);
    bus_read(A_PRESET, r); check("preset_readback", r, 32'd3);

    // Mode 1, PRESET=2: periodic one-cycle pulses; then mask with IM=0
    run_trial(2, 1, 1'b1, 2 * (2 * P + 2) + 4);
    bus_write(A_CTRL, 32'h3);
    bus_read(A_COUNT, first_c);
    changed = 1'b0;
    for (int i = 0; i < 3 * (2 * P + 2); i++) begin
      @(negedge Clock);
      bus_read(A_COUNT, r);
      if (r != first_c) changed = 1'b1;
      check($sformatf("im_off_irq_%0d", i), {31'd0, IRQ}, 32'd0);
    end
    check("im_off_count_moves", {31'd0, changed}, 32'd1);

    // Mode 0 with IM=0, then set IM through a CTRL write
    run_trial(2, 0, 1'b0, 2 * P + 8);
    bus_write(A_CTRL, 32'hFFFF_FFF8);
    bus_read(A_CTRL, r); check("ctrl_upper_bits_ignored", r, 32'h8);
    check("im_set_after_stop_no_irq", {31'd0, IRQ}, 32'd0);
    repeat (4) @(negedge Clock);
    bus_read(A_COUNT, r); check("stopped_count_zero", r, 32'd0);
    check("stopped_irq_zero", {31'd0, IRQ}, 32'd0);
    check("stopped_state_idle", {30'd0, dbg_state}, 32'd0);

    // PRESET rewrite mid-count, reload picks it up, COUNT write ignored
    do_reset();
    bus_write(A_PRESET, 32'd4);
    bus_write(A_CTRL, 32'hB);
    found = 1'b0;
    for (int i = 0; i < 20 * P && !found; i++) begin
      bus_read(A_COUNT, r);
      if (r == 32'd2) found = 1'b1;
      else @(negedge Clock);
    end
    check("mid_count_reached_2", {31'd0, found}, 32'd1);
    bus_write(A_PRESET, 32'd7);
    found = 1'b0;
    maxc  = 32'd0;
    for (int i = 0; i < 20 * P && !found; i++) begin
      bus_read(A_COUNT, r);
      if (r > maxc) maxc = r;
      if (IRQ) found = 1'b1;
      else @(negedge Clock);
    end
    check("mid_count_irq_seen", {31'd0, found}, 32'd1);
    check("mid_count_finishes_from_2", {31'd0, (maxc <= 32'd2)}, 32'd1);
    @(negedge Clock);
    bus_read(A_COUNT, r); check("reload_uses_new_preset", r, 32'd7);
    check("reload_pulse_one_cycle", {31'd0, IRQ}, 32'd0);
    bus_write(A_COUNT, 32'h1234);
    bus_read(A_COUNT, r); check("count_write_ignored", r, 32'(7 - 1 / P));

    // Reset mid-count: immediate zeros, and nothing restarts afterwards
    do_reset();
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'h9);
    repeat (3) @(negedge Clock);
    model(5, 0, 1'b1, 3, c, q, r);
    bus_read(A_COUNT, r); check("pre_reset_count", r, c);
    #1;
    Reset = 1'b0;
    #1;
    bus_read(A_CTRL, r);   check("async_rst_ctrl", r, 32'd0);
    bus_read(A_PRESET, r); check("async_rst_preset", r, 32'd0);
    bus_read(A_COUNT, r);  check("async_rst_count", r, 32'd0);
    check("async_rst_irq", {31'd0, IRQ}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (5 * P + 8) @(negedge Clock);
    bus_read(A_CTRL, r);  check("post_rst_ctrl", r, 32'd0);
    bus_read(A_COUNT, r); check("post_rst_count", r, 32'd0);
    check("post_rst_irq", {31'd0, IRQ}, 32'd0);
    check("post_rst_state", {30'd0, dbg_state}, 32'd0);

    // Randomized trials against the timing model
    for (int t = 0; t < 8; t++) begin
      n    = int'($urandom_range(0, 6));
      mode = int'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      run_trial(n, mode, im, 2 * (n * P + 3) + 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
